acc_controller: RTL and testbench

Multi-cycle control unit for the 8-bit accumulator machine. Fetches instructions from a shared memory port using a req/ack handshake, latches them into an internal instruction register, decodes them, and sequences the accumulator, ALU and program counter. It drives `loadAcc` on the accumulator and the control lines of the PC and ALU. It is the only master of the memory port.

---
 rtl/acc_cpu_pkg.sv | 38 +++
 rtl/instr_decoder.sv | 63 ++++++
 rtl/acc_controller.sv | 131 +++++++++++++
 tb/tb_acc_controller.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the 8-bit accumulator machine: opcodes, ALU encodings,
// controller state encoding and default widths.
package acc_cpu_pkg;

  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefAddrW = 4;

  localparam logic [3:0] OpNop = 4'h0;
  localparam logic [3:0] OpLda = 4'h1;
  localparam logic [3:0] OpSta = 4'h2;
  localparam logic [3:0] OpAdd = 4'h3;
  localparam logic [3:0] OpSub = 4'h4;
  localparam logic [3:0] OpAnd = 4'h5;
  localparam logic [3:0] OpOr  = 4'h6;
  localparam logic [3:0] OpXor = 4'h7;
  localparam logic [3:0] OpNot = 4'h8;
  localparam logic [3:0] OpJmp = 4'h9;
  localparam logic [3:0] OpJz  = 4'hA;
  localparam logic [3:0] OpHlt = 4'hF;

  localparam logic [2:0] AluPass = 3'b000;
  localparam logic [2:0] AluAdd  = 3'b001;
  localparam logic [2:0] AluSub  = 3'b010;
  localparam logic [2:0] AluAnd  = 3'b011;
  localparam logic [2:0] AluOr   = 3'b100;
  localparam logic [2:0] AluXor  = 3'b101;
  localparam logic [2:0] AluNot  = 3'b110;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StMemRd,
    StMemWr,
    StHalt
  } ctrl_state_e;

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode decoder for the accumulator controller.
// Unknown opcodes decode to all-zero, which the controller executes as NOP.
module instr_decoder
  import acc_cpu_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       needsRead,
  output logic       needsWrite,
  output logic       isJump,
  output logic       isCondJump,
  output logic       isNot,
  output logic       isHalt,
  output logic [2:0] aluOp,
  output logic       accSrc
);

  always_comb begin
    needsRead  = 1'b0;
    needsWrite = 1'b0;
    isJump     = 1'b0;
    isCondJump = 1'b0;
    isNot      = 1'b0;
    isHalt     = 1'b0;
    aluOp      = AluPass;
    accSrc     = 1'b0;
    unique case (opcode)
      OpLda: begin
        needsRead = 1'b1;
        accSrc    = 1'b1;
      end
      OpSta: needsWrite = 1'b1;
      OpAdd: begin
        needsRead = 1'b1;
        aluOp     = AluAdd;
      end
      OpSub: begin
        needsRead = 1'b1;
        aluOp     = AluSub;
      end
      OpAnd: begin
        needsRead = 1'b1;
        aluOp     = AluAnd;
      end
      OpOr: begin
        needsRead = 1'b1;
        aluOp     = AluOr;
      end
      OpXor: begin
        needsRead = 1'b1;
        aluOp     = AluXor;
      end
      OpNot: begin
        isNot = 1'b1;
        aluOp = AluNot;
      end
      OpJmp: isJump     = 1'b1;
      OpJz:  isCondJump = 1'b1;
      OpHlt: isHalt     = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/acc_controller.sv
// Multi-cycle control FSM for the accumulator machine: fetches over a req/ack
// memory port, holds the instruction register and sequences PC, ALU and acc.
module acc_controller
  import acc_cpu_pkg::*;
#(
  parameter int unsigned DATAW = DefDataW,
  parameter int unsigned ADDRW = DefAddrW
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             run,
  input  logic [DATAW-1:0] memRdata,
  input  logic             memAck,
  input  logic             accZero,
  output logic             memReq,
  output logic             memWe,
  output logic             addrSel,
  output logic [ADDRW-1:0] operandAddr,
  output logic             pcInc,
  output logic             pcLoad,
  output logic [2:0]       aluOp,
  output logic             accSrc,
  output logic             loadAcc,
  output logic             halted
);

  ctrl_state_e      stateQ, stateD;
  logic [DATAW-1:0] irQ, irD;
  // Delay flop holds the inverted run level, so its reset value of 0 means
  // "run not yet seen low": a run held high across reset release cannot fire.
  logic             runLowQ;
  logic             runRise;

  logic       decNeedsRead, decNeedsWrite, decIsJump, decIsCondJump;
  logic       decIsNot, decIsHalt, decAccSrc;
  logic [2:0] decAluOp;

  instr_decoder uDecoder (
    .opcode    (irQ[DATAW-1 -: 4]),
    .needsRead (decNeedsRead),
    .needsWrite(decNeedsWrite),
    .isJump    (decIsJump),
    .isCondJump(decIsCondJump),
    .isNot     (decIsNot),
    .isHalt    (decIsHalt),
    .aluOp     (decAluOp),
    .accSrc    (decAccSrc)
  );

  assign runRise     = run & runLowQ;
  assign operandAddr = irQ[ADDRW-1:0];

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      stateQ  <= StIdle;
      irQ     <= '0;
      runLowQ <= 1'b0;
    end else begin
      stateQ  <= stateD;
      irQ     <= irD;
      runLowQ <= ~run;
    end
  end

  always_comb begin
    stateD  = stateQ;
    irD     = irQ;
    memReq  = 1'b0;
    memWe   = 1'b0;
    addrSel = 1'b0;
    pcInc   = 1'b0;
    pcLoad  = 1'b0;
    aluOp   = AluPass;
    accSrc  = 1'b0;
    loadAcc = 1'b0;
    halted  = 1'b0;
    unique case (stateQ)
      StIdle: begin
        halted = 1'b1;
        if (runRise) stateD = StFetch;
      end
      StFetch: begin
        memReq = 1'b1;
        if (memAck) begin
          irD    = memRdata;
          pcInc  = 1'b1;
          stateD = StDecode;
        end
      end
      StDecode: begin
        if (decIsHalt) begin
          stateD = StHalt;
        end else if (decNeedsRead) begin
          stateD = StMemRd;
        end else if (decNeedsWrite) begin
          stateD = StMemWr;
        end else begin
          stateD = StFetch;
          pcLoad = decIsJump | (decIsCondJump & accZero);
          if (decIsNot) begin
            loadAcc = 1'b1;
            aluOp   = decAluOp;
          end
        end
      end
      StMemRd: begin
        memReq  = 1'b1;
        addrSel = 1'b1;
        // aluOp/accSrc held for the whole wait so the datapath sees stable controls
        aluOp   = decAluOp;
        accSrc  = decAccSrc;
        if (memAck) begin
          loadAcc = 1'b1;
          stateD  = StFetch;
        end
      end
      StMemWr: begin
        memReq  = 1'b1;
        memWe   = 1'b1;
        addrSel = 1'b1;
        if (memAck) stateD = StFetch;
      end
      StHalt: begin
        halted = 1'b1;
        if (runRise) stateD = StFetch;
      end
      default: stateD = StIdle;
    endcase
  end

endmodule

// File: tb/tb_acc_controller.sv
// Directed bench for acc_controller: drives memAck/memRdata cycle by cycle and
// checks the decoded control outputs against hand-computed values.
module tb_acc_controller;

  logic       clk;
  logic       resetN;
  logic       run;
  logic [7:0] memRdata;
  logic       memAck;
  logic       accZero;
  logic       memReq;
  logic       memWe;
  logic       addrSel;
  logic [3:0] operandAddr;
  logic       pcInc;
  logic       pcLoad;
  logic [2:0] aluOp;
  logic       accSrc;
  logic       loadAcc;
  logic       halted;

  int nChecks = 0;
  int nPass   = 0;

  acc_controller #(
    .DATAW(8),
    .ADDRW(4)
  ) dut (
    .clk        (clk),
    .resetN     (resetN),
    .run        (run),
    .memRdata   (memRdata),
    .memAck     (memAck),
    .accZero    (accZero),
    .memReq     (memReq),
    .memWe      (memWe),
    .addrSel    (addrSel),
    .operandAddr(operandAddr),
    .pcInc      (pcInc),
    .pcLoad     (pcLoad),
    .aluOp      (aluOp),
    .accSrc     (accSrc),
    .loadAcc    (loadAcc),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic nextCycle();
    @(negedge clk);
    memAck   = 1'b0;
    memRdata = 8'h00;
  endtask

  task automatic fetchInstr(input logic [7:0] ins);
    memAck   = 1'b1;
    memRdata = ins;
    #1;
    chk("fetchReq", memReq, 1);
    chk("fetchAddrSel", addrSel, 0);
    chk("fetchPcInc", pcInc, 1);
    chk("fetchHalted", halted, 0);
    nextCycle();
  endtask

  task automatic expectFetchIdle();
    #1;
    chk("backToFetchReq", memReq, 1);
    chk("backToFetchAddrSel", addrSel, 0);
    chk("backToFetchLoadAcc", loadAcc, 0);
  endtask

  initial begin
    resetN   = 1'b0;
    run      = 1'b1;
    memAck   = 1'b0;
    memRdata = 8'h00;
    accZero  = 1'b0;
    @(negedge clk);
    #1;
    chk("rstHalted", halted, 1);
    chk("rstMemReq", memReq, 0);
    chk("rstOthers", {memWe, addrSel, operandAddr, pcInc, pcLoad, aluOp, accSrc, loadAcc}, 0);
    @(negedge clk);
    resetN = 1'b1;

    // run already high at release must not start execution
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      #1;
      chk("idleHeldHalted", halted, 1);
      chk("idleHeldNoReq", memReq, 0);
    end
    nextCycle();
    run = 1'b0;
    nextCycle();
    run = 1'b1;
    #1;
    chk("idleEdgeCycleNoReq", memReq, 0);
    nextCycle();

    // LDA 0xA, zero wait
    fetchInstr(8'h1A);
    #1;
    chk("ldaDecNoReq", memReq, 0);
    chk("ldaDecPcInc", pcInc, 0);
    chk("ldaDecOperand", operandAddr, 4'hA);
    nextCycle();
    memAck   = 1'b1;
    memRdata = 8'h3C;
    #1;
    chk("ldaRdReq", memReq, 1);
    chk("ldaRdAddrSel", addrSel, 1);
    chk("ldaRdOperand", operandAddr, 4'hA);
    chk("ldaRdLoadAcc", loadAcc, 1);
    chk("ldaRdAccSrc", accSrc, 1);
    chk("ldaRdWe", memWe, 0);
    nextCycle();
    expectFetchIdle();

    // ADD 0x5 with three wait cycles
    fetchInstr(8'h35);
    nextCycle();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("addWaitReq", memReq, 1);
      chk("addWaitAddrSel", addrSel, 1);
      chk("addWaitAluOp", aluOp, 3'b001);
      chk("addWaitLoadAcc", loadAcc, 0);
      nextCycle();
    end
    memAck = 1'b1;
    #1;
    chk("addAckReq", memReq, 1);
    chk("addAckAluOp", aluOp, 3'b001);
    chk("addAckAccSrc", accSrc, 0);
    chk("addAckLoadAcc", loadAcc, 1);
    nextCycle();
    expectFetchIdle();

    // STA 0x7, one wait cycle
    fetchInstr(8'h27);
    nextCycle();
    #1;
    chk("staWe", memWe, 1);
    chk("staAddrSel", addrSel, 1);
    chk("staOperand", operandAddr, 4'h7);
    chk("staLoadAcc", loadAcc, 0);
    nextCycle();
    memAck = 1'b1;
    #1;
    chk("staAckWe", memWe, 1);
    chk("staAckLoadAcc", loadAcc, 0);
    nextCycle();
    expectFetchIdle();

    // JZ taken, then not taken
    fetchInstr(8'hA5);
    accZero = 1'b1;
    #1;
    chk("jzTakenPcLoad", pcLoad, 1);
    chk("jzTakenNoReq", memReq, 0);
    nextCycle();
    expectFetchIdle();
    fetchInstr(8'hA5);
    accZero = 1'b0;
    #1;
    chk("jzNotTakenPcLoad", pcLoad, 0);
    nextCycle();
    expectFetchIdle();

    // NOT, JMP and an unassigned opcode
    fetchInstr(8'h80);
    #1;
    chk("notLoadAcc", loadAcc, 1);
    chk("notAluOp", aluOp, 3'b110);
    chk("notAccSrc", accSrc, 0);
    nextCycle();
    expectFetchIdle();
    fetchInstr(8'h93);
    #1;
    chk("jmpPcLoad", pcLoad, 1);
    chk("jmpOperand", operandAddr, 4'h3);
    nextCycle();
    expectFetchIdle();
    fetchInstr(8'hC4);
    #1;
    chk("nopCtrl", {memReq, pcLoad, loadAcc, aluOp}, 0);
    nextCycle();
    expectFetchIdle();

    // HLT; run is still held high from earlier
    fetchInstr(8'hF0);
    #1;
    chk("hltDecHalted", halted, 0);
    nextCycle();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("haltHalted", halted, 1);
      chk("haltNoReq", memReq, 0);
      chk("haltIrHeld", operandAddr, 4'h0);
      nextCycle();
    end
    run = 1'b0;
    nextCycle();
    run = 1'b1;
    nextCycle();
    #1;
    chk("resumeReq", memReq, 1);
    chk("resumeAddrSel", addrSel, 0);
    chk("resumeHalted", halted, 0);

    // Reset during a waiting MEMRD abandons the request at once
    fetchInstr(8'h1B);
    nextCycle();
    #1;
    chk("preRstRdReq", memReq, 1);
    resetN = 1'b0;
    #1;
    chk("asyncRstReq", memReq, 0);
    chk("asyncRstHalted", halted, 1);
    chk("asyncRstIr", operandAddr, 4'h0);
    nextCycle();
    resetN = 1'b1;
    nextCycle();
    #1;
    chk("postRstIdle", {halted, memReq}, 2'b10);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
